// File: rtl/alu_exec_seq_pkg.sv
// Shared types and constants for the ALU execute/writeback sequencer.
// Command classification lives here so the FSM and the strobe decoder agree on it.
package alu_exec_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEx,
        StWb,
        StSettle,
        StWbh,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        KindAlu,
        KindStore,
        KindTest,
        KindIllegal
    } cmd_kind_e;

    localparam int unsigned CMD_ADD      = 0;
    localparam int unsigned CMD_SUB      = 1;
    localparam int unsigned CMD_MPY      = 2;
    localparam int unsigned CMD_AND      = 3;
    localparam int unsigned CMD_OR       = 4;
    localparam int unsigned CMD_XOR      = 5;
    localparam int unsigned CMD_SHR      = 6;
    localparam int unsigned CMD_SHL      = 7;
    localparam int unsigned CMD_STOREH   = 8;
    localparam int unsigned CMD_TEST_GEZ = 9;
    localparam int unsigned CMD_TEST_Z   = 10;

    localparam int unsigned FLG_ZF = 4;
    localparam int unsigned FLG_NF = 1;
    localparam int unsigned FLG_MF = 0;

    function automatic cmd_kind_e cmd_kind(input int unsigned cmd);
        if (cmd <= CMD_SHL) begin
            return KindAlu;
        end else if (cmd == CMD_STOREH) begin
            return KindStore;
        end else if (cmd == CMD_TEST_GEZ || cmd == CMD_TEST_Z) begin
            return KindTest;
        end
        return KindIllegal;
    endfunction

endpackage

// File: rtl/alu_exec_seq_dec.sv
// Combinational strobe decoder: state register plus latched command to ALU/bus controls.
// Only the WBH gating and the DONE-cycle flag test look at live inputs.
module alu_exec_seq_dec
    import alu_exec_seq_pkg::*;
#(
    parameter int unsigned CMD_W  = 4,
    parameter int unsigned FLAG_W = 5
) (
    input  state_e             state_i,
    input  logic [CMD_W-1:0]   cmd_i,
    input  logic               user_sample_i,
    input  logic [FLAG_W-1:0]  flags_i,
    output logic               ready_o,
    output logic               alu_en_o,
    output logic               c9_o,
    output logic               c10_o,
    output logic               acc_load_o,
    output logic               mem_wr_o,
    output logic               done_o,
    output logic               taken_o,
    output logic               err_o
);

    cmd_kind_e kind;
    logic      unused_flags;

    assign unused_flags = ^flags_i;

    always_comb begin
        kind     = cmd_kind(32'(cmd_i));
        ready_o  = 1'b0;
        alu_en_o = 1'b0;
        c9_o     = 1'b0;
        c10_o    = 1'b0;
        done_o   = 1'b0;
        taken_o  = 1'b0;
        err_o    = 1'b0;
        unique case (state_i)
            StIdle:   ready_o  = 1'b1;
            StEx:     alu_en_o = 1'b1;
            StWb:     c9_o     = 1'b1;
            StSettle: ;
            // A user MR peek owns the bus; hold off the MR drive until it ends.
            StWbh:    c10_o    = ~user_sample_i;
            StDone: begin
                done_o = 1'b1;
                err_o  = (kind == KindIllegal);
                if (cmd_i == CMD_W'(CMD_TEST_GEZ)) begin
                    taken_o = ~flags_i[FLG_NF];
                end else if (cmd_i == CMD_W'(CMD_TEST_Z)) begin
                    taken_o = flags_i[FLG_ZF];
                end
            end
            default: ;
        endcase
        acc_load_o = c9_o;
        mem_wr_o   = c10_o;
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute/writeback sequencer between the instruction decoder and the ALU/ACC.
// Accepts one command per handshake and steps the ALU strobes through EX/WB/SETTLE/DONE.
module alu_exec_seq
    import alu_exec_seq_pkg::*;
#(
    parameter int unsigned CMD_W     = 4,
    parameter int unsigned FLAG_W    = 5,
    parameter int unsigned WB_SETTLE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [CMD_W-1:0]  i_cmd,
    input  logic              i_flush,
    input  logic              i_user_sample,
    input  logic [FLAG_W-1:0] i_flags,
    output logic [2:0]        ctrl_alu_op,
    output logic              ctrl_alu_en,
    output logic              C9,
    output logic              C10,
    output logic              o_acc_load,
    output logic              o_mem_wr,
    output logic              o_done,
    output logic              o_taken,
    output logic              o_err
);

    localparam logic [1:0] SettleInit = (WB_SETTLE == 0) ? 2'd0 : 2'(WB_SETTLE - 1);

    state_e           state_q;
    logic [CMD_W-1:0] cmd_q;
    logic [1:0]       settle_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            settle_q <= '0;
        end else if (i_flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_cmd_valid) begin
                        cmd_q <= i_cmd;
                        unique case (cmd_kind(32'(i_cmd)))
                            KindAlu:   state_q <= StEx;
                            KindStore: state_q <= StWbh;
                            default:   state_q <= StDone;
                        endcase
                    end
                end
                StEx: state_q <= StWb;
                StWb: begin
                    if (WB_SETTLE == 0) begin
                        state_q <= StDone;
                    end else begin
                        settle_q <= SettleInit;
                        state_q  <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_q == 2'd0) begin
                        state_q <= StDone;
                    end else begin
                        settle_q <= settle_q - 2'd1;
                    end
                end
                StWbh: begin
                    if (!i_user_sample) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ctrl_alu_op = cmd_q[2:0];

    alu_exec_seq_dec #(
        .CMD_W  (CMD_W),
        .FLAG_W (FLAG_W)
    ) u_dec (
        .state_i       (state_q),
        .cmd_i         (cmd_q),
        .user_sample_i (i_user_sample),
        .flags_i       (i_flags),
        .ready_o       (o_cmd_ready),
        .alu_en_o      (ctrl_alu_en),
        .c9_o          (C9),
        .c10_o         (C10),
        .acc_load_o    (o_acc_load),
        .mem_wr_o      (o_mem_wr),
        .done_o        (o_done),
        .taken_o       (o_taken),
        .err_o         (o_err)
    );

endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq: directed commands push expected completions,
// a negedge monitor pops and compares on every o_done.
module tb_alu_exec_seq;

    typedef struct {
        int         lat;
        int         en_at;
        int         c9_at;
        int         c10_at;
        logic       err;
        logic       taken;
        logic [2:0] op;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic       valid0;
    logic [3:0] cmd_r;
    logic       flush;
    logic       user_sample;
    logic [4:0] flags;

    logic       ready, en, c9, c10, acc_load, mem_wr, done, taken, err;
    logic [2:0] op;
    logic       ready0, en0, c90, c100, acc_load0, mem_wr0, done0, taken0, err0;
    logic [2:0] op0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    alu_exec_seq #(.CMD_W(4), .FLAG_W(5), .WB_SETTLE(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(valid), .o_cmd_ready(ready),
        .i_cmd(cmd_r), .i_flush(flush), .i_user_sample(user_sample), .i_flags(flags),
        .ctrl_alu_op(op), .ctrl_alu_en(en), .C9(c9), .C10(c10), .o_acc_load(acc_load),
        .o_mem_wr(mem_wr), .o_done(done), .o_taken(taken), .o_err(err)
    );

    alu_exec_seq #(.CMD_W(4), .FLAG_W(5), .WB_SETTLE(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(valid0), .o_cmd_ready(ready0),
        .i_cmd(cmd_r), .i_flush(flush), .i_user_sample(user_sample), .i_flags(flags),
        .ctrl_alu_op(op0), .ctrl_alu_en(en0), .C9(c90), .C10(c100), .o_acc_load(acc_load0),
        .o_mem_wr(mem_wr0), .o_done(done0), .o_taken(taken0), .o_err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic exp_t mk(input int lat, input int en_at, input int c9_at,
                                input int c10_at, input logic e_err, input logic e_taken,
                                input logic [2:0] e_op);
        exp_t e;
        e.lat = lat; e.en_at = en_at; e.c9_at = c9_at; e.c10_at = c10_at;
        e.err = e_err; e.taken = e_taken; e.op = e_op;
        return e;
    endfunction

    // Monitor: per-cycle invariants plus scoreboard compare on each completion.
    initial begin
        int         acc_cyc = 0;
        int         n_en = 0, n_c9 = 0, n_c10 = 0;
        int         en_at = 0, c9_at = 0, c10_at = 0;
        bit         chk_next = 0;
        logic [2:0] last_op = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_next = 0;
                continue;
            end
            chk("coincidence",
                32'((acc_load === c9) && (mem_wr === c10) && (int'(en) + int'(c9) + int'(c10) <= 1)
                    && !((taken || err) && !done)), 32'd1);
            if (chk_next) begin
                chk("ready_after_done", 32'(ready), 32'd1);
                chk("op_hold_idle", 32'(op), 32'(last_op));
                chk_next = 0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("err", 32'(err), 32'(e.err));
                    chk("taken", 32'(taken), 32'(e.taken));
                    chk("op", 32'(op), 32'(e.op));
                    chk("en_at", en_at, e.en_at);
                    chk("en_cnt", n_en, 32'(e.en_at != 0));
                    chk("c9_at", c9_at, e.c9_at);
                    chk("c9_cnt", n_c9, 32'(e.c9_at != 0));
                    chk("c10_at", c10_at, e.c10_at);
                    chk("c10_cnt", n_c10, 32'(e.c10_at != 0));
                    chk("ready_in_done", 32'(ready), 32'd0);
                    last_op  = e.op;
                    chk_next = 1;
                end
            end
            if (en)  begin n_en++;  if (en_at == 0)  en_at  = cyc - acc_cyc; end
            if (c9)  begin n_c9++;  if (c9_at == 0)  c9_at  = cyc - acc_cyc; end
            if (c10) begin n_c10++; if (c10_at == 0) c10_at = cyc - acc_cyc; end
            if (ready && valid && !flush) begin
                acc_cyc = cyc;
                n_en = 0; n_c9 = 0; n_c10 = 0;
                en_at = 0; c9_at = 0; c10_at = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first cycle after the accept edge.
    task automatic issue(input logic [3:0] c, input logic [4:0] f, input bit push,
                         input exp_t e, input int hold);
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        cmd_r = c;
        flags = f;
        valid = 1'b1;
        if (hold > 0) user_sample = 1'b1;
        if (push) q.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            user_sample = 1'b0;
        end
    endtask

    initial begin
        exp_t none;
        int   en_at0, c9_at0, done_at0, n;
        none = mk(0, 0, 0, 0, 1'b0, 1'b0, 3'd0);
        rst_n = 1'b1; valid = 1'b0; valid0 = 1'b0; cmd_r = '0;
        flush = 1'b0; user_sample = 1'b0; flags = '0;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_strobes", 32'({en, c9, c10, acc_load, mem_wr, done, taken, err}), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_ready0", 32'(ready0), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD, SETTLE=1: en +1, C9 +2, done +4
        issue(4'h0, 5'b0, 1, mk(4, 1, 2, 0, 1'b0, 1'b0, 3'd0), 0);
        // MPY then STOREH back-to-back
        issue(4'h2, 5'b0, 1, mk(4, 1, 2, 0, 1'b0, 1'b0, 3'd2), 0);
        issue(4'h8, 5'b0, 1, mk(2, 0, 0, 1, 1'b0, 1'b0, 3'd0), 0);
        // STOREH with user sample for 3 cycles
        issue(4'h8, 5'b0, 1, mk(5, 0, 0, 4, 1'b0, 1'b0, 3'd0), 3);
        // Branch tests
        issue(4'h9, 5'b00010, 1, mk(1, 0, 0, 0, 1'b0, 1'b0, 3'd1), 0);
        issue(4'hA, 5'b10000, 1, mk(1, 0, 0, 0, 1'b0, 1'b1, 3'd2), 0);
        issue(4'h9, 5'b00000, 1, mk(1, 0, 0, 0, 1'b0, 1'b1, 3'd1), 0);
        issue(4'hA, 5'b01111, 1, mk(1, 0, 0, 0, 1'b0, 1'b0, 3'd2), 0);

        // Flush in EX of SUB
        issue(4'h1, 5'b0, 0, none, 0);
        chk("flush_ex_en", 32'(en), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("flush_quiet", 32'({c9, done}), 32'd0);
            @(posedge clk); #1;
        end

        // Flush coincident with valid in IDLE: not accepted
        cmd_r = 4'h0; valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        chk("flush_idle_ready", 32'(ready), 32'd1);
        chk("flush_idle_en", 32'(en), 32'd0);

        // Illegal command
        issue(4'hC, 5'b0, 1, mk(1, 0, 0, 0, 1'b1, 1'b0, 3'd4), 0);
        issue(4'h7, 5'b0, 1, mk(4, 1, 2, 0, 1'b0, 1'b0, 3'd7), 0);

        // WB_SETTLE=0 instance: done at +3
        n = 0;
        while (!(ready0 && ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_r = 4'h0; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        en_at0 = 0; c9_at0 = 0; done_at0 = 0;
        for (int k = 1; k <= 8; k++) begin
            if (en0 && en_at0 == 0) en_at0 = k;
            if (c90 && c9_at0 == 0) c9_at0 = k;
            if (done0 && done_at0 == 0) done_at0 = k;
            @(posedge clk); #1;
        end
        chk("s0_en_at", en_at0, 32'd1);
        chk("s0_c9_at", c9_at0, 32'd2);
        chk("s0_done_at", done_at0, 32'd3);

        // Asynchronous reset mid-command
        issue(4'h0, 5'b0, 0, none, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(en), 32'd0);
        chk("arst_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(4'h3, 5'b0, 1, mk(4, 1, 2, 0, 1'b0, 1'b0, 3'd3), 0);

        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
